// File: rtl/video_pkg.sv
// Shared types for the video stream checker: FSM states and coordinate width.
package video_pkg;

  localparam int unsigned COORD_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE,
    DONE
  } state_t;

  // Channel-wise compare with the low tol bits of every channel ignored.
  function automatic logic pix_differs(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned ch,
    input int unsigned dw,
    input int unsigned tol
  );
    logic        diff;
    logic [63:0] mask;
    diff = 1'b0;
    mask = (64'd1 << dw) - 64'd1;
    for (int unsigned c = 0; c < ch; c++) begin
      if ((((a >> (c * dw)) & mask) >> tol) != (((b >> (c * dw)) & mask) >> tol)) diff = 1'b1;
    end
    return diff;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding expected pixels; a pop at full makes room for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic [CNTW-1:0]  count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNTW'(1);
    else if (do_pop && !do_push) count_nxt = count - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNTW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/video_stream_checker.sv
// Compares a DUT video stream against expected pixels queued in a FIFO and
// reports a per-frame verdict, mismatch count and first error location.
module video_stream_checker
  import video_pkg::*;
#(
  parameter int unsigned HRES  = 1600,
  parameter int unsigned VRES  = 900,
  parameter int unsigned CH    = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned TOL   = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dv,
  input  logic               hs,
  input  logic               vs,
  input  logic [CH*DW-1:0]   pix,
  input  logic               exp_valid,
  input  logic [CH*DW-1:0]   exp_data,
  output logic               exp_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               pass,
  output logic [31:0]        mism_cnt,
  output logic [10:0]        first_x,
  output logic [10:0]        first_y,
  output logic               first_vld,
  output logic               underflow,
  output logic               size_err
);

  localparam int unsigned PW   = CH * DW;
  localparam int unsigned NPIX = HRES * VRES;

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [31:0]        pix_cnt;

  logic               fifo_full;
  logic               fifo_empty;
  logic [PW-1:0]      fifo_rd_c;

  logic               px_c;
  logic               pop_c;
  logic               push_c;
  logic               miss_c;
  logic               err_c;
  logic               last_c;
  logic               early_vs_c;
  logic               end_c;
  logic [31:0]        mism_nxt_c;
  logic               under_nxt_c;
  logic               size_nxt_c;
  logic               unused_hs;

  assign unused_hs = hs;

  assign px_c      = (state == ACTIVE) && dv;
  assign pop_c     = px_c && !fifo_empty;
  assign exp_ready = !fifo_full || pop_c;
  assign push_c    = exp_valid && exp_ready;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .pop       (pop_c),
    .din       (exp_data),
    .rd_data_c (fifo_rd_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign miss_c = pix_differs(64'(pix), 64'(fifo_rd_c), CH, DW, TOL);

  // An empty FIFO on a dv cycle is an error in its own right.
  always_comb begin
    err_c       = px_c && (fifo_empty || miss_c);
    last_c      = px_c && (pix_cnt == 32'(NPIX - 1));
    early_vs_c  = (state == ACTIVE) && vs && !last_c;
    end_c       = last_c || early_vs_c;
    mism_nxt_c  = mism_cnt;
    if (err_c && (mism_cnt != '1)) mism_nxt_c = mism_cnt + 32'd1;
    under_nxt_c = underflow || (px_c && fifo_empty);
    size_nxt_c  = size_err || early_vs_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pass       <= 1'b0;
      mism_cnt   <= '0;
      first_x    <= '0;
      first_y    <= '0;
      first_vld  <= 1'b0;
      underflow  <= 1'b0;
      size_err   <= 1'b0;
      x          <= '0;
      y          <= '0;
      pix_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WAIT_VS;
            busy      <= 1'b1;
            pass      <= 1'b0;
            mism_cnt  <= '0;
            first_vld <= 1'b0;
            underflow <= 1'b0;
            size_err  <= 1'b0;
          end
        end
        WAIT_VS: begin
          if (vs) begin
            state   <= ACTIVE;
            x       <= '0;
            y       <= '0;
            pix_cnt <= '0;
          end
        end
        ACTIVE: begin
          mism_cnt  <= mism_nxt_c;
          underflow <= under_nxt_c;
          size_err  <= size_nxt_c;
          if (err_c && !first_vld) begin
            first_vld <= 1'b1;
            first_x   <= x;
            first_y   <= y;
          end
          if (px_c) begin
            pix_cnt <= pix_cnt + 32'd1;
            if (x == COORD_W'(HRES - 1)) begin
              x <= '0;
              y <= y + COORD_W'(1);
            end else begin
              x <= x + COORD_W'(1);
            end
          end
          // Verdict includes the error state produced by this very cycle.
          if (end_c) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            pass       <= (mism_nxt_c == '0) && !under_nxt_c && !size_nxt_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Scoreboard bench for video_stream_checker on a 4x2 frame with 3x8-bit pixels.
module tb_video_stream_checker;

  localparam int unsigned HRES  = 4;
  localparam int unsigned VRES  = 2;
  localparam int unsigned CH    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned TOL   = 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = CH * DW;
  localparam int          NPIX  = HRES * VRES;

  typedef struct {
    int mism;
    bit under;
    bit size;
    bit fvld;
    int fx;
    int fy;
    bit pass;
  } res_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          dv;
  logic          hs;
  logic          vs;
  logic [PW-1:0] pix;
  logic          exp_valid;
  logic [PW-1:0] exp_data;
  logic          exp_ready;
  logic          busy;
  logic          frame_done;
  logic          pass;
  logic [31:0]   mism_cnt;
  logic [10:0]   first_x;
  logic [10:0]   first_y;
  logic          first_vld;
  logic          underflow;
  logic          size_err;

  video_stream_checker #(
    .HRES(HRES), .VRES(VRES), .CH(CH), .DW(DW), .TOL(TOL), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dv(dv), .hs(hs), .vs(vs), .pix(pix),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .busy(busy), .frame_done(frame_done), .pass(pass), .mism_cnt(mism_cnt),
    .first_x(first_x), .first_y(first_y), .first_vld(first_vld),
    .underflow(underflow), .size_err(size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int fd_count;

  logic [PW-1:0] mq[$];
  res_t          sb[$];

  int m_mism, m_n, m_x, m_y, m_fx, m_fy;
  bit m_under, m_size, m_fvld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] gen();
    logic [PW-1:0] d;
    d      = PW'($urandom);
    d[7:0] = d[7:0] & 8'h7E;
    return d;
  endfunction

  function automatic bit differs(input logic [PW-1:0] a, input logic [PW-1:0] b);
    bit d;
    d = 0;
    for (int c = 0; c < CH; c++) begin
      if ((a[c*DW +: DW] >> TOL) != (b[c*DW +: DW] >> TOL)) d = 1;
    end
    return d;
  endfunction

  task automatic model_start();
    m_mism = 0; m_n = 0; m_x = 0; m_y = 0; m_fx = 0; m_fy = 0;
    m_under = 0; m_size = 0; m_fvld = 0;
  endtask

  task automatic model_pixel(input logic [PW-1:0] p, input bit v, output bit ended);
    bit bad;
    logic [PW-1:0] e;
    if (mq.size() > 0) begin
      e   = mq.pop_front();
      bad = differs(p, e);
    end else begin
      bad     = 1;
      m_under = 1;
    end
    if (bad) begin
      m_mism++;
      if (!m_fvld) begin m_fvld = 1; m_fx = m_x; m_fy = m_y; end
    end
    m_n++;
    if (m_x == HRES - 1) begin m_x = 0; m_y++; end else m_x++;
    ended = 0;
    if (m_n == NPIX) ended = 1;
    else if (v) begin m_size = 1; ended = 1; end
    if (ended) sb.push_back('{m_mism, m_under, m_size, m_fvld, m_fx, m_fy,
                              (m_mism == 0) && !m_under && !m_size});
  endtask

  task automatic push_exp(input logic [PW-1:0] d);
    exp_valid = 1'b1;
    exp_data  = d;
    #1;
    check("exp_ready", exp_ready, mq.size() < DEPTH);
    if (mq.size() < DEPTH) mq.push_back(d);
    tick();
    exp_valid = 1'b0;
  endtask

  // vs_mode: 0 no vs, 1 vs with the last dv, 2 vs the cycle after the last dv.
  task automatic run_frame(input int npix, input int vs_mode, input int err_idx,
                           input int err_amt, input bit push_first);
    logic [PW-1:0] p;
    logic [PW-1:0] d;
    bit ended;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_armed", busy, 1);
    model_start();
    vs  = 1'b1;
    dv  = 1'b1;
    pix = PW'($urandom);
    tick();
    vs = 1'b0;
    dv = 1'b0;
    for (int i = 0; i < npix; i++) begin
      p = (mq.size() > 0) ? mq[0] : PW'($urandom);
      if (i == err_idx) p[7:0] = p[7:0] + 8'(err_amt);
      dv  = 1'b1;
      pix = p;
      vs  = (vs_mode == 1) && (i == npix - 1);
      if (push_first && i == 0) begin
        d         = gen();
        exp_valid = 1'b1;
        exp_data  = d;
      end
      #1;
      if (push_first && i == 0) check("ready_pop_at_full", exp_ready, 1);
      model_pixel(p, vs, ended);
      if (push_first && i == 0) mq.push_back(d);
      @(posedge clk);
      #1;
      dv = 1'b0; vs = 1'b0; exp_valid = 1'b0;
      check("frame_done_dv", frame_done, ended);
    end
    if (vs_mode == 2) begin
      vs     = 1'b1;
      m_size = 1;
      sb.push_back('{m_mism, m_under, m_size, m_fvld, m_fx, m_fy, 0});
      tick();
      vs = 1'b0;
      check("frame_done_vs", frame_done, 1);
    end
    for (int k = 0; k < 4 && sb.size() != 0; k++) tick();
    check("sb_drained", sb.size(), 0);
    check("busy_done", busy, 0);
    check("frame_done_once", frame_done, 0);
  endtask

  // Completion monitor: every frame_done pops one expected verdict.
  always begin
    res_t r;
    @(posedge clk);
    #2;
    if (frame_done) begin
      fd_count++;
      if (sb.size() == 0) check("frame_done_unexpected", 1, 0);
      else begin
        r = sb.pop_front();
        check("mism_cnt", mism_cnt, r.mism);
        check("underflow", underflow, r.under);
        check("size_err", size_err, r.size);
        check("first_vld", first_vld, r.fvld);
        if (r.fvld) begin
          check("first_x", first_x, r.fx);
          check("first_y", first_y, r.fy);
        end
        check("pass", pass, r.pass);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int fd_before;
    logic [PW-1:0] p;
    bit ended;
    n_checks = 0; n_errors = 0; fd_count = 0;
    rst = 1'b0; start = 1'b0; dv = 1'b0; hs = 1'b0; vs = 1'b0;
    pix = '0; exp_valid = 1'b0; exp_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_exp_ready", exp_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pass", pass, 0);
    check("rst_mism_cnt", mism_cnt, 0);
    check("rst_first_x", first_x, 0);
    check("rst_first_y", first_y, 0);
    check("rst_first_vld", first_vld, 0);
    check("rst_underflow", underflow, 0);
    check("rst_size_err", size_err, 0);

    // Identical streams.
    for (int i = 0; i < NPIX; i++) push_exp(gen());
    run_frame(NPIX, 0, -1, 0, 0);

    // Red off by one at (2,1) is inside tolerance; off by two is not.
    for (int i = 0; i < NPIX; i++) push_exp(gen());
    run_frame(NPIX, 0, 6, 1, 0);
    for (int i = 0; i < NPIX; i++) push_exp(gen());
    run_frame(NPIX, 0, 6, 2, 0);
    check("tol_first_x", first_x, 2);
    check("tol_first_y", first_y, 1);
    check("tol_mism_cnt", mism_cnt, 1);

    // Underflow on the 4th pixel, then frame cut short by vs.
    for (int i = 0; i < 3; i++) push_exp(gen());
    run_frame(4, 2, -1, 0, 0);
    check("uf_underflow", underflow, 1);
    check("uf_first_x", first_x, 3);
    check("uf_first_y", first_y, 0);
    check("uf_pass", pass, 0);

    // vs arriving with the 6th pixel; leftovers stay in the FIFO.
    for (int i = 0; i < NPIX; i++) push_exp(gen());
    run_frame(6, 1, -1, 0, 0);
    check("early_size_err", size_err, 1);
    check("early_pass", pass, 0);

    // Reset in the middle of a frame that already has an error.
    start = 1'b1; tick(); start = 1'b0;
    model_start();
    vs = 1'b1; tick(); vs = 1'b0;
    p = mq[0];
    dv = 1'b1; pix = p; model_pixel(p, 0, ended); tick();
    p = ~mq[0];
    pix = p; model_pixel(p, 0, ended); tick();
    dv = 1'b0;
    check("pre_rst_mism", mism_cnt, 1);
    check("pre_rst_first_x", first_x, 1);
    fd_before = fd_count;
    rst = 1'b0;
    tick();
    mq.delete();
    check("arst_busy", busy, 0);
    check("arst_mism_cnt", mism_cnt, 0);
    check("arst_first_x", first_x, 0);
    check("arst_first_vld", first_vld, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_pass", pass, 0);
    rst = 1'b1;
    repeat (3) tick();
    check("arst_no_done", fd_count, fd_before);
    check("arst_exp_ready", exp_ready, 1);

    // Fill to full, reject a 17th push, then push while popping at full.
    for (int i = 0; i < DEPTH + 1; i++) push_exp(gen());
    check("full_ready_low", exp_ready, 0);
    run_frame(NPIX, 0, -1, 0, 1);
    check("full_after_pop_push", exp_ready, 1);
    run_frame(NPIX, 0, -1, 0, 0);
    for (int i = 0; i < NPIX - 1; i++) push_exp(gen());
    run_frame(NPIX, 0, -1, 0, 0);
    check("fifo_drained_model", mq.size(), 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
